// File: rtl/stack_ctrl.sv
// Stack pointer sequencer: turns push/pop/load requests into
// ordered SP pulses and handshaked data-memory accesses.
module stack_ctrl #(
  parameter int unsigned          DATA_W      = 16,
  parameter logic [DATA_W-1:0]    STACK_BASE  = '0,
  parameter logic [DATA_W-1:0]    STACK_LIMIT = 'h0100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              load_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] load_val,
  input  logic [DATA_W-1:0] sp,
  output logic              sp_inc,
  output logic              sp_dec,
  output logic              sp_write,
  output logic [DATA_W-1:0] sp_wdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pop_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_MEM,
    S_PUSH_INC,
    S_POP_DEC,
    S_POP_MEM,
    S_POP_DONE,
    S_LOAD
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // State and latched operand registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      pop_data_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pop_data_q <= pop_data_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Next state: accept in IDLE only, load > push > pop
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pop_data_d = pop_data_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          data_d  = load_val;
        end else if (push_req) begin
          if (sp == STACK_LIMIT) begin
            ovf_d = 1'b1;
          end else begin
            state_d = S_PUSH_MEM;
            data_d  = push_data;
          end
        end else if (pop_req) begin
          if (sp == STACK_BASE) begin
            unf_d = 1'b1;
          end else begin
            state_d = S_POP_DEC;
          end
        end
      end
      S_PUSH_MEM: if (mem_ready) state_d = S_PUSH_INC;
      S_PUSH_INC: state_d = S_IDLE;
      S_POP_DEC:  state_d = S_POP_MEM;
      S_POP_MEM: begin
        if (mem_ready) begin
          pop_data_d = mem_rdata;
          state_d    = S_POP_DONE;
        end
      end
      S_POP_DONE: state_d = S_IDLE;
      S_LOAD:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched operand
  always_comb begin
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    sp_write  = 1'b0;
    sp_wdata  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_PUSH_MEM: begin
        mem_we    = 1'b1;
        mem_addr  = sp;
        mem_wdata = data_q;
      end
      S_PUSH_INC: begin
        sp_inc = 1'b1;
        done   = 1'b1;
      end
      S_POP_DEC: sp_dec = 1'b1;
      S_POP_MEM: begin
        mem_re   = 1'b1;
        mem_addr = sp;
      end
      S_POP_DONE: done = 1'b1;
      S_LOAD: begin
        sp_write = 1'b1;
        sp_wdata = data_q;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign pop_data  = pop_data_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: SP register and memory models around
// the DUT, directed scenarios plus random ops against a stack model.
module tb_stack_ctrl;

  localparam logic [15:0] LIMIT = 16'h0100;
  localparam int K_PUSH = 0;
  localparam int K_POP  = 1;
  localparam int K_LOAD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        push_req = 1'b0, pop_req = 1'b0, load_req = 1'b0;
  logic [15:0] push_data = '0, load_val = '0;
  logic [15:0] sp;
  logic        sp_inc, sp_dec, sp_write;
  logic [15:0] sp_wdata, mem_addr, mem_wdata;
  logic        mem_we, mem_re, mem_ready;
  logic [15:0] mem_rdata, pop_data;
  logic        busy, done, overflow, underflow;

  int checks = 0;
  int errors = 0;

  stack_ctrl dut (
    .clock(clock), .reset(reset),
    .push_req(push_req), .pop_req(pop_req), .load_req(load_req),
    .push_data(push_data), .load_val(load_val), .sp(sp),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_write(sp_write),
    .sp_wdata(sp_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pop_data(pop_data), .busy(busy),
    .done(done), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // SP register environment
  logic [15:0] sp_r;
  always @(posedge clock) begin
    if (reset) sp_r <= '0;
    else if (sp_write) sp_r <= sp_wdata;
    else if (sp_inc) sp_r <= sp_r + 16'd1;
    else if (sp_dec) sp_r <= sp_r - 16'd1;
  end
  assign sp = sp_r;

  // Data memory with programmable wait states
  logic [15:0] mem [0:511];
  int acc_cnt = 0;
  int wait_cycles = 0;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      acc_cnt <= 0;
    end else begin
      if (!(mem_we || mem_re) || mem_ready) acc_cnt <= 0;
      else acc_cnt <= acc_cnt + 1;
      if (mem_we && mem_ready) mem[mem_addr[8:0]] <= mem_wdata;
    end
  end
  assign mem_ready = (mem_we || mem_re) && (acc_cnt >= wait_cycles);
  assign mem_rdata = mem_re ? mem[mem_addr[8:0]] : 16'h0;

  // Reference model state
  logic [15:0] ref_sp;
  logic [15:0] ref_pop;
  logic [15:0] ref_mem [0:511];

  // Observations of one operation
  int o_lat, o_done, o_ovf, o_unf, o_inc, o_dec, o_wr, o_we, o_re, o_multi;
  logic [15:0] o_waddr, o_wdata, o_raddr, o_spw, o_pop;

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    push_req = 1'b0; pop_req = 1'b0; load_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ref_sp = '0;
    ref_pop = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
  endtask

  task automatic op(input int kind, input logic [15:0] val, input int w);
    wait_cycles = w;
    @(negedge clock);
    push_data = val;
    load_val  = val;
    push_req  = (kind == K_PUSH);
    pop_req   = (kind == K_POP);
    load_req  = (kind == K_LOAD);
    @(posedge clock);
    #1;
    push_req = 1'b0; pop_req = 1'b0; load_req = 1'b0;
    o_lat = 0; o_done = 0; o_ovf = 0; o_unf = 0; o_inc = 0;
    o_dec = 0; o_wr = 0; o_we = 0; o_re = 0; o_multi = 0;
    o_waddr = 'x; o_wdata = 'x; o_raddr = 'x; o_spw = 'x; o_pop = 'x;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (sp_inc) o_inc++;
      if (sp_dec) o_dec++;
      if (sp_write) begin o_wr++; o_spw = sp_wdata; end
      if (int'(sp_inc) + int'(sp_dec) + int'(sp_write) > 1) o_multi++;
      if (mem_we) begin o_we++; o_waddr = mem_addr; o_wdata = mem_wdata; end
      if (mem_re) begin o_re++; o_raddr = mem_addr; end
      if (done) o_done++;
      if (overflow) o_ovf++;
      if (underflow) o_unf++;
      if (done || overflow || underflow) begin
        o_lat = k;
        o_pop = pop_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({sp_inc, sp_dec, sp_write, mem_we, mem_re, busy, done,
         overflow, underflow} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0", {sp_inc, sp_dec, sp_write,
               mem_we, mem_re, busy, done, overflow, underflow});
    end
    checks++;
    if ({sp_wdata, mem_addr, mem_wdata, pop_data} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {sp_wdata, mem_addr, mem_wdata, pop_data});
    end
  endtask

  task automatic test_push_basic();
    apply_reset();
    op(K_PUSH, 16'hBEEF, 0);
    checks++;
    if (o_lat != 2 || o_done != 1 || o_inc != 1 || o_we != 1) begin
      errors++;
      $display("FAIL push_timing got lat=%0d done=%0d inc=%0d we=%0d want 2 1 1 1",
               o_lat, o_done, o_inc, o_we);
    end
    checks++;
    if (o_waddr !== 16'h0 || o_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL push_write got %h/%h want 0000/beef", o_waddr, o_wdata);
    end
    @(negedge clock);
    checks++;
    if (sp !== 16'h1) begin
      errors++;
      $display("FAIL push_sp got %h want 0001", sp);
    end
  endtask

  task automatic test_lifo();
    logic [15:0] p1, p2;
    int l1, l2;
    apply_reset();
    op(K_PUSH, 16'h1111, 0);
    op(K_PUSH, 16'h2222, 0);
    op(K_POP, 16'h0, 0);
    p1 = o_pop; l1 = o_lat;
    op(K_POP, 16'h0, 0);
    p2 = o_pop; l2 = o_lat;
    checks++;
    if (p1 !== 16'h2222 || p2 !== 16'h1111) begin
      errors++;
      $display("FAIL lifo_data got %h,%h want 2222,1111", p1, p2);
    end
    checks++;
    if (l1 != 3 || l2 != 3) begin
      errors++;
      $display("FAIL lifo_lat got %0d,%0d want 3,3", l1, l2);
    end
    @(negedge clock);
    checks++;
    if (sp !== 16'h0) begin
      errors++;
      $display("FAIL lifo_sp got %h want 0000", sp);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    op(K_POP, 16'h0, 0);
    checks++;
    if (o_unf != 1 || o_lat != 1 || o_dec != 0 || o_re != 0 || o_done != 0) begin
      errors++;
      $display("FAIL underflow got unf=%0d lat=%0d dec=%0d re=%0d done=%0d want 1 1 0 0 0",
               o_unf, o_lat, o_dec, o_re, o_done);
    end
    @(negedge clock);
    checks++;
    if (underflow !== 1'b0 || sp !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underflow_after got unf=%b sp=%h busy=%b want 0 0000 0",
               underflow, sp, busy);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    op(K_LOAD, LIMIT, 0);
    checks++;
    if (o_lat != 1 || o_wr != 1 || o_spw !== LIMIT || o_done != 1) begin
      errors++;
      $display("FAIL load got lat=%0d wr=%0d val=%h done=%0d want 1 1 0100 1",
               o_lat, o_wr, o_spw, o_done);
    end
    op(K_PUSH, 16'h7777, 0);
    checks++;
    if (o_ovf != 1 || o_lat != 1 || o_we != 0 || o_inc != 0 || o_done != 0) begin
      errors++;
      $display("FAIL overflow got ovf=%0d lat=%0d we=%0d inc=%0d done=%0d want 1 1 0 0 0",
               o_ovf, o_lat, o_we, o_inc, o_done);
    end
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0 || sp !== LIMIT) begin
      errors++;
      $display("FAIL overflow_after got ovf=%b sp=%h want 0 0100", overflow, sp);
    end
  endtask

  task automatic test_priority();
    int n_we, n_dec, n_re, dones, order_ok;
    logic [15:0] waddr, raddr, pd;
    n_we = 0; n_dec = 0; n_re = 0; dones = 0; order_ok = 1;
    waddr = 'x; raddr = 'x; pd = 'x;
    apply_reset();
    op(K_LOAD, 16'd5, 0);
    wait_cycles = 0;
    @(negedge clock);
    push_data = 16'hA5C3;
    push_req  = 1'b1;
    pop_req   = 1'b1;
    for (int k = 0; k < 40 && dones < 2; k++) begin
      @(negedge clock);
      if (mem_we) begin n_we++; waddr = mem_addr; end
      if (sp_dec) begin if (n_we == 0) order_ok = 0; n_dec++; end
      if (mem_re) begin if (n_dec == 0) order_ok = 0; n_re++; raddr = mem_addr; end
      if (done) begin
        dones++;
        if (dones == 1) push_req = 1'b0;
        else begin pop_req = 1'b0; pd = pop_data; end
      end
    end
    push_req = 1'b0;
    pop_req  = 1'b0;
    checks++;
    if (dones != 2 || order_ok != 1 || n_dec != 1) begin
      errors++;
      $display("FAIL prio_order got dones=%0d order=%0d dec=%0d want 2 1 1",
               dones, order_ok, n_dec);
    end
    checks++;
    if (waddr !== 16'd5 || raddr !== 16'd5 || pd !== 16'hA5C3) begin
      errors++;
      $display("FAIL prio_data got wa=%h ra=%h pd=%h want 0005 0005 a5c3",
               waddr, raddr, pd);
    end
    @(negedge clock);
    checks++;
    if (sp !== 16'd5) begin
      errors++;
      $display("FAIL prio_sp got %h want 0005", sp);
    end
  endtask

  task automatic test_wait_reset();
    int n_bad;
    n_bad = 0;
    apply_reset();
    op(K_PUSH, 16'h1234, 0);
    op(K_POP, 16'h0, 1);
    checks++;
    if (o_pop !== 16'h1234 || o_lat != 4) begin
      errors++;
      $display("FAIL wait_pop got pd=%h lat=%0d want 1234 4", o_pop, o_lat);
    end
    wait_cycles = 3;
    @(negedge clock);
    push_data = 16'h5A5A;
    push_req  = 1'b1;
    @(posedge clock);
    #1;
    push_req = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_we !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold got we=%b rdy=%b want 1 0", mem_we, mem_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || pop_data !== 16'h0) begin
      errors++;
      $display("FAIL abort got we=%b busy=%b pd=%h want 0 0 0000",
               mem_we, busy, pop_data);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (sp_inc || done || mem_we) n_bad++;
    end
    checks++;
    if (n_bad != 0 || sp !== 16'h0) begin
      errors++;
      $display("FAIL abort_after got bad=%0d sp=%h want 0 0000", n_bad, sp);
    end
  endtask

  task automatic test_random();
    int kind, w, sel;
    int e_lat, e_done, e_ovf, e_unf, e_inc, e_dec, e_wr, e_we, e_re;
    logic [15:0] val, e_addr;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 9);
      kind = (sel < 5) ? K_PUSH : (sel < 9) ? K_POP : K_LOAD;
      w    = $urandom_range(0, 2);
      val  = 16'($urandom);
      if (kind == K_LOAD) begin
        sel = $urandom_range(0, 3);
        val = (sel == 0) ? LIMIT : (sel == 1) ? LIMIT - 16'd1 :
              (sel == 2) ? 16'h0 : 16'($urandom_range(0, 256));
      end
      e_lat = 1; e_done = 0; e_ovf = 0; e_unf = 0; e_inc = 0;
      e_dec = 0; e_wr = 0; e_we = 0; e_re = 0; e_addr = 'x;
      if (kind == K_PUSH) begin
        if (ref_sp == LIMIT) e_ovf = 1;
        else begin
          e_lat = 2 + w; e_done = 1; e_inc = 1; e_we = 1 + w;
          e_addr = ref_sp;
          ref_mem[ref_sp[8:0]] = val;
          ref_sp = ref_sp + 16'd1;
        end
      end else if (kind == K_POP) begin
        if (ref_sp == 16'h0) e_unf = 1;
        else begin
          ref_sp = ref_sp - 16'd1;
          e_lat = 3 + w; e_done = 1; e_dec = 1; e_re = 1 + w;
          e_addr = ref_sp;
          ref_pop = ref_mem[ref_sp[8:0]];
        end
      end else begin
        e_done = 1; e_wr = 1;
        ref_sp = val;
      end
      op(kind, val, w);
      checks++;
      if (o_lat != e_lat || o_done != e_done || o_ovf != e_ovf || o_unf != e_unf) begin
        errors++;
        $display("FAIL rnd%0d_ctl k=%0d got lat=%0d d=%0d o=%0d u=%0d want %0d %0d %0d %0d",
                 n, kind, o_lat, o_done, o_ovf, o_unf, e_lat, e_done, e_ovf, e_unf);
      end
      checks++;
      if (o_inc != e_inc || o_dec != e_dec || o_wr != e_wr || o_we != e_we ||
          o_re != e_re || o_multi != 0) begin
        errors++;
        $display("FAIL rnd%0d_pulses got %0d %0d %0d %0d %0d m=%0d want %0d %0d %0d %0d %0d m=0",
                 n, o_inc, o_dec, o_wr, o_we, o_re, o_multi,
                 e_inc, e_dec, e_wr, e_we, e_re);
      end
      if (e_we > 0) begin
        checks++;
        if (o_waddr !== e_addr || o_wdata !== val) begin
          errors++;
          $display("FAIL rnd%0d_write got %h/%h want %h/%h",
                   n, o_waddr, o_wdata, e_addr, val);
        end
      end
      if (e_re > 0) begin
        checks++;
        if (o_raddr !== e_addr) begin
          errors++;
          $display("FAIL rnd%0d_raddr got %h want %h", n, o_raddr, e_addr);
        end
      end
      if (e_wr > 0) begin
        checks++;
        if (o_spw !== val) begin
          errors++;
          $display("FAIL rnd%0d_load got %h want %h", n, o_spw, val);
        end
      end
      checks++;
      if (o_pop !== ref_pop) begin
        errors++;
        $display("FAIL rnd%0d_pop got %h want %h", n, o_pop, ref_pop);
      end
      @(negedge clock);
      checks++;
      if (sp !== ref_sp || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_sp got %h busy=%b want %h 0", n, sp, busy, ref_sp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_lifo();
    test_underflow();
    test_overflow();
    test_priority();
    test_wait_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
